// File: rtl/sme_driver.sv
// Host-side driver for a string-matching engine: buffers a string and a pattern,
// streams them to the engine, then waits for a result or a timeout.
module sme_driver #(
  parameter int unsigned STR_MAX = 32,
  parameter int unsigned PAT_MAX = 9,
  parameter int unsigned TMO     = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic       wr_sel,
  input  logic [7:0] wr_data,
  input  logic       clr,
  input  logic       start,
  input  logic       keep_str,
  output logic [7:0] chardata,
  output logic       isstring,
  output logic       ispattern,
  input  logic       valid,
  input  logic       match,
  input  logic [4:0] match_index,
  output logic       busy,
  output logic       res_valid,
  output logic       res_match,
  output logic [4:0] res_index,
  output logic       res_timeout
);

  localparam int unsigned SLW = $clog2(STR_MAX + 1);
  localparam int unsigned PLW = $clog2(PAT_MAX + 1);
  localparam int unsigned IW  = (SLW > PLW) ? SLW : PLW;
  localparam int unsigned SAW = (STR_MAX > 1) ? $clog2(STR_MAX) : 1;
  localparam int unsigned PAW = (PAT_MAX > 1) ? $clog2(PAT_MAX) : 1;

  typedef enum logic [2:0] {IDLE, SEND_STR, SEND_PAT, WAIT, REPORT} state_e;

  state_e           state_q, state_d;
  logic [SLW-1:0]   str_len_q, str_len_d;
  logic [PLW-1:0]   pat_len_q, pat_len_d;
  logic [IW-1:0]    idx_q, idx_d, nidx;
  logic [7:0]       wcnt_q, wcnt_d;
  logic             str_sent_q, str_sent_d;
  logic [7:0]       chardata_q, chardata_d;
  logic             isstring_q, isstring_d;
  logic             ispattern_q, ispattern_d;
  logic             busy_q;
  logic             res_valid_q, res_valid_d;
  logic             res_match_q, res_match_d;
  logic [4:0]       res_index_q, res_index_d;
  logic             res_timeout_q, res_timeout_d;
  logic             str_we, pat_we;
  logic             accept;

  logic [7:0] str_mem [STR_MAX];
  logic [7:0] pat_mem [PAT_MAX];

  assign chardata    = chardata_q;
  assign isstring    = isstring_q;
  assign ispattern   = ispattern_q;
  assign busy        = busy_q;
  assign res_valid   = res_valid_q;
  assign res_match   = res_match_q;
  assign res_index   = res_index_q;
  assign res_timeout = res_timeout_q;

  assign nidx   = idx_q + IW'(1);
  assign accept = (pat_len_q != '0) &&
                  (keep_str ? str_sent_q : (str_len_q != '0));

  // Next-state and registered-output logic
  always_comb begin
    state_d       = state_q;
    str_len_d     = str_len_q;
    pat_len_d     = pat_len_q;
    idx_d         = idx_q;
    wcnt_d        = wcnt_q;
    str_sent_d    = str_sent_q;
    chardata_d    = 8'h00;
    isstring_d    = 1'b0;
    ispattern_d   = 1'b0;
    res_valid_d   = 1'b0;
    res_match_d   = res_match_q;
    res_index_d   = res_index_q;
    res_timeout_d = res_timeout_q;
    str_we        = 1'b0;
    pat_we        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          // A write coinciding with start is always dropped, accepted or not.
          if (accept) begin
            idx_d = '0;
            if (keep_str) begin
              state_d     = SEND_PAT;
              ispattern_d = 1'b1;
              chardata_d  = pat_mem[0];
            end else begin
              state_d    = SEND_STR;
              isstring_d = 1'b1;
              chardata_d = str_mem[0];
            end
          end
        end else if (clr) begin
          str_len_d  = '0;
          pat_len_d  = '0;
          str_sent_d = 1'b0;
        end else if (wr_en) begin
          if (!wr_sel) begin
            if (str_len_q != SLW'(STR_MAX)) begin
              str_we    = 1'b1;
              str_len_d = str_len_q + SLW'(1);
            end
          end else begin
            if (pat_len_q != PLW'(PAT_MAX)) begin
              pat_we    = 1'b1;
              pat_len_d = pat_len_q + PLW'(1);
            end
          end
        end
      end

      SEND_STR: begin
        if (nidx == IW'(str_len_q)) begin
          str_sent_d  = 1'b1;
          state_d     = SEND_PAT;
          idx_d       = '0;
          ispattern_d = 1'b1;
          chardata_d  = pat_mem[0];
        end else begin
          idx_d      = nidx;
          isstring_d = 1'b1;
          chardata_d = str_mem[SAW'(nidx)];
        end
      end

      SEND_PAT: begin
        if (nidx == IW'(pat_len_q)) begin
          state_d = WAIT;
          wcnt_d  = 8'h00;
        end else begin
          idx_d       = nidx;
          ispattern_d = 1'b1;
          chardata_d  = pat_mem[PAW'(nidx)];
        end
      end

      WAIT: begin
        if (valid) begin
          res_match_d   = match;
          res_index_d   = match_index;
          res_timeout_d = 1'b0;
          res_valid_d   = 1'b1;
          state_d       = REPORT;
        end else if (wcnt_q == 8'(TMO - 1)) begin
          res_match_d   = 1'b0;
          res_index_d   = 5'd0;
          res_timeout_d = 1'b1;
          res_valid_d   = 1'b1;
          state_d       = REPORT;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end

      REPORT: begin
        pat_len_d = '0;
        state_d   = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      str_len_q     <= '0;
      pat_len_q     <= '0;
      idx_q         <= '0;
      wcnt_q        <= 8'h00;
      str_sent_q    <= 1'b0;
      chardata_q    <= 8'h00;
      isstring_q    <= 1'b0;
      ispattern_q   <= 1'b0;
      busy_q        <= 1'b0;
      res_valid_q   <= 1'b0;
      res_match_q   <= 1'b0;
      res_index_q   <= 5'd0;
      res_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      str_len_q     <= str_len_d;
      pat_len_q     <= pat_len_d;
      idx_q         <= idx_d;
      wcnt_q        <= wcnt_d;
      str_sent_q    <= str_sent_d;
      chardata_q    <= chardata_d;
      isstring_q    <= isstring_d;
      ispattern_q   <= ispattern_d;
      busy_q        <= (state_d != IDLE);
      res_valid_q   <= res_valid_d;
      res_match_q   <= res_match_d;
      res_index_q   <= res_index_d;
      res_timeout_q <= res_timeout_d;
    end
  end

  // Buffer storage carries no reset; lengths alone define valid content
  always_ff @(posedge clk) begin
    if (str_we) str_mem[SAW'(str_len_q)] <= wr_data;
    if (pat_we) pat_mem[PAW'(pat_len_q)] <= wr_data;
  end

endmodule

// File: tb/tb_sme_driver.sv
// Scoreboard bench for sme_driver: stimulus queues expected characters and results,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_sme_driver;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0, wr_sel = 1'b0, clr = 1'b0, start = 1'b0, keep_str = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       valid = 1'b0, match = 1'b0;
  logic [4:0] match_index = 5'd0;
  logic [7:0] chardata;
  logic       isstring, ispattern, busy, res_valid, res_match, res_timeout;
  logic [4:0] res_index;

  sme_driver dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .clr(clr), .start(start), .keep_str(keep_str), .chardata(chardata),
    .isstring(isstring), .ispattern(ispattern), .valid(valid), .match(match),
    .match_index(match_index), .busy(busy), .res_valid(res_valid),
    .res_match(res_match), .res_index(res_index), .res_timeout(res_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic is_str; logic [7:0] c; } ch_t;
  typedef struct packed { logic m; logic [4:0] i; logic t; logic [15:0] gap; } res_t;

  ch_t  exp_ch[$];
  res_t exp_res[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: char stream, idle chardata, exclusivity, results and WAIT gap
  int   since_pat = 0;
  ch_t  ec;
  res_t er;
  always @(negedge clk) begin
    if (reset) begin
      since_pat = 0;
    end else begin
      if (isstring && ispattern) chk("exclusive_flags", 32'd1, 32'd0);
      if (isstring || ispattern) begin
        if (exp_ch.size() == 0) chk("unexpected_char", 32'({isstring, chardata}), 32'h1ff);
        else begin
          ec = exp_ch.pop_front();
          chk("char", 32'({isstring, chardata}), 32'(ec));
        end
      end else if (chardata != 8'h00) begin
        chk("idle_chardata", 32'(chardata), 32'd0);
      end
      if (ispattern) since_pat = 0;
      else since_pat++;
      if (res_valid) begin
        if (exp_res.size() == 0) chk("unexpected_res_valid", 32'd1, 32'd0);
        else begin
          er = exp_res.pop_front();
          chk("res_match", 32'(res_match), 32'(er.m));
          chk("res_index", 32'(res_index), 32'(er.i));
          chk("res_timeout", 32'(res_timeout), 32'(er.t));
          chk("wait_gap", 32'(since_pat), 32'(er.gap));
        end
      end
    end
  end

  task automatic put(input logic sel, input logic [7:0] d);
    wr_en = 1'b1; wr_sel = sel; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic put_str(input logic sel, input string s);
    for (int i = 0; i < s.len(); i++) put(sel, s[i]);
  endtask

  task automatic exp_chars(input logic is_str, input string s);
    for (int i = 0; i < s.len(); i++) exp_ch.push_back({is_str, s[i]});
  endtask

  task automatic push_res(input logic m, input logic [4:0] i, input logic t, input int gap);
    exp_res.push_back({m, i, t, 16'(gap)});
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic start_job(input logic keep);
    start = 1'b1; keep_str = keep;
    @(negedge clk);
    start = 1'b0; keep_str = 1'b0;
  endtask

  // Returns at the first negedge of WAIT (pattern strobe just dropped)
  task automatic wait_pat_end();
    logic seen;
    logic done;
    seen = ispattern;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (ispattern) seen = 1'b1;
      else if (seen) done = 1'b1;
    end
    if (!done) chk("pat_end_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input int limit);
    logic done;
    done = 1'b0;
    for (int i = 0; i < limit && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    if (!done) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic drive_valid(input logic m, input logic [4:0] idx);
    valid = 1'b1; match = m; match_index = idx;
    @(negedge clk);
    valid = 1'b0; match = 1'b0; match_index = 5'd0;
  endtask

  task automatic expect_quiet(input string nm);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk(nm, 32'(busy), 32'd0);
    end
  endtask

  initial begin
    int cnt;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_isstring", 32'(isstring), 32'd0);
    chk("rst_ispattern", 32'(ispattern), 32'd0);
    chk("rst_chardata", 32'(chardata), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_match", 32'(res_match), 32'd0);
    chk("rst_res_index", 32'(res_index), 32'd0);
    chk("rst_res_timeout", 32'(res_timeout), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Full job, engine answers on the second WAIT cycle
    pulse_clr();
    put_str(1'b0, "ab cd");
    put_str(1'b1, "cd");
    exp_chars(1'b1, "ab cd");
    exp_chars(1'b0, "cd");
    push_res(1'b1, 5'd3, 1'b0, 3);
    start_job(1'b0);
    wait_pat_end();
    @(negedge clk);
    drive_valid(1'b1, 5'd3);
    wait_idle(50);
    repeat (3) @(negedge clk);
    chk("hold_res_match", 32'(res_match), 32'd1);
    chk("hold_res_index", 32'(res_index), 32'd3);
    chk("hold_res_timeout", 32'(res_timeout), 32'd0);

    // Reuse the string, new pattern, engine answers on the first WAIT cycle
    put_str(1'b1, "^ab");
    exp_ch.push_back({1'b0, 8'h5E});
    exp_ch.push_back({1'b0, 8'h61});
    exp_ch.push_back({1'b0, 8'h62});
    push_res(1'b0, 5'd17, 1'b0, 2);
    start_job(1'b1);
    wait_pat_end();
    drive_valid(1'b0, 5'd17);
    wait_idle(50);

    // Rejected starts: empty pattern, then keep_str after clr (write alongside is dropped)
    start_job(1'b0);
    expect_quiet("reject_no_pat");
    pulse_clr();
    put(1'b1, "x");
    wr_en = 1'b1; wr_sel = 1'b1; wr_data = "y";
    start_job(1'b1);
    wr_en = 1'b0;
    expect_quiet("reject_keep_after_clr");

    // Timeout job; a valid pulse during the pattern phase must be ignored
    put_str(1'b0, "q");
    put_str(1'b1, "zw");
    exp_chars(1'b1, "q");
    exp_chars(1'b0, "xzw");
    push_res(1'b0, 5'd0, 1'b1, 256);
    start_job(1'b0);
    cnt = 0;
    for (int i = 0; i < 20 && !ispattern; i++) @(negedge clk);
    chk("pat_phase_reached", 32'(ispattern), 32'd1);
    drive_valid(1'b1, 5'd9);
    wait_idle(400);

    // String overflow: 34 writes keep only 32 characters
    pulse_clr();
    for (int i = 0; i < 34; i++) put(1'b0, 8'(8'h41 + i));
    put(1'b1, "!");
    for (int i = 0; i < 32; i++) exp_ch.push_back({1'b1, 8'(8'h41 + i)});
    exp_ch.push_back({1'b0, 8'h21});
    push_res(1'b1, 5'd31, 1'b0, 3);
    start_job(1'b0);
    wait_pat_end();
    @(negedge clk);
    drive_valid(1'b1, 5'd31);
    wait_idle(100);

    // Reset during the string phase aborts the job with no result
    put(1'b1, "k");
    exp_chars(1'b1, "ABC");
    start_job(1'b0);
    cnt = isstring ? 1 : 0;
    for (int i = 0; i < 20 && cnt < 3; i++) begin
      @(negedge clk);
      if (isstring) cnt++;
    end
    #1 reset = 1'b1;
    #1;
    chk("abort_isstring", 32'(isstring), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_res_valid", 32'(res_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    start_job(1'b0);
    expect_quiet("post_reset_lengths_cleared");

    chk("chars_left", 32'(exp_ch.size()), 32'd0);
    chk("results_left", 32'(exp_res.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
